// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 slave.
// Consumed by spi_sync and spi_slave; see spi_slave.sv for the SPI_SLAVE_OVERRUN_EN option.
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int SYNC_DEPTH = 2;
    localparam int CNT_W      = $clog2(BYTE_W);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, with rise/fall
// pulses derived from the synchronised level. RESET_VAL is the line's idle level.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
)
(
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_DEPTH{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign sync_o = sync_q[SYNC_DEPTH-1];
    assign rise_o =  sync_o & ~prev_q;
    assign fall_o = ~sync_o &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0), oversampled on clk with one TX buffer.
// Optional `define SPI_SLAVE_OVERRUN_EN adds a sticky overrun output and drops unread bytes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | CS high; MISO held 0, SCK edges ignored
// ACTIVE | CS low; bytes shift in on SCK rise, out on SCK fall
module spi_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic              overrun,
`endif
    input  logic              rx_ack
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl,  cs_rise,  cs_fall;
    logic mosi_s,  mosi_rise, mosi_fall;

    spi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(SCK),
        .sync_o (sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(CS),
        .sync_o (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(MOSI),
        .sync_o (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    // Not every channel needs both its level and its edges.
    logic unused_sync;
    assign unused_sync = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_state_e            state_q,    state_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-2:0]     rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]     tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]     tx_buf_q,   tx_buf_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [BYTE_W-1:0]     rx_data_q,  rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  consume;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  overrun_q,  overrun_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        consume    = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_d  = overrun_q;
`endif

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    consume   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SPI_SLAVE_OVERRUN_EN
                        if (rx_valid_q && !rx_ack) begin
                            overrun_d = 1'b1;
                        end else begin
                            rx_data_d  = {rx_shift_q, mosi_s};
                            rx_valid_d = 1'b1;
                        end
`else
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
`endif
                    end
                end else if (sck_fall) begin
                    // Counter at zero on a fall means a byte just finished: start the next one.
                    if (bit_cnt_q == '0) begin
                        consume = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            tx_shift_d = tx_ready_q ? '0 : tx_buf_q;
            tx_ready_d = 1'b1;
        end

        // A load seen alongside a consume lands after it, leaving the buffer full.
        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q  <= overrun_d;
`endif
        end
    end

    assign MISO     = (state_q == ACTIVE) & tx_shift_q[BYTE_W-1];
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign overrun  = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: SPI mode-0 master at clk/10.
// Build with or without SPI_SLAVE_OVERRUN_EN, matching the RTL build.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       overrun;
`endif

    int total = 0;
    int bad   = 0;

    spi_slave dut (
        .clk     (clk),
        .reset   (reset),
        .SCK     (SCK),
        .CS      (CS),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
`ifdef SPI_SLAVE_OVERRUN_EN
        .overrun (overrun),
`endif
        .rx_ack  (rx_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All master actions start on a falling clk edge and move in multiples of 10 ns.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = b[7-i];
            #50;
            SCK = 1'b1;
            got[7-i] = MISO;
            #50;
            SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        CS = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #50;
        CS = 1'b1;
        #100;
    endtask

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", MISO); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
`ifdef SPI_SLAVE_OVERRUN_EN
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`endif
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        load_tx(8'hA5);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL single_tx_ready_loaded got=%b exp=0", tx_ready); end
        cs_low();
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL single_tx_ready_consumed got=%b exp=1", tx_ready); end
        total++; if (MISO !== 1'b1) begin bad++; $display("FAIL single_miso_first got=%b exp=1", MISO); end
        send_bits(8'hFF, 8, got);
        total++; if (got !== 8'hA5) begin bad++; $display("FAIL single_miso_byte got=%h exp=a5", got); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL single_rx_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL single_rx_data got=%h exp=ff", rx_data); end
        cs_high();
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL single_miso_idle got=%b exp=0", MISO); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        ack();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_ack_clears got=%b exp=0", rx_valid); end
        load_tx(8'hA5);
        cs_low();
        send_bits(8'h3C, 8, got);
        total++; if (got !== 8'hA5) begin bad++; $display("FAIL b2b_miso_first got=%h exp=a5", got); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_first got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL b2b_data_first got=%h exp=3c", rx_data); end
        ack();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_ack_first got=%b exp=0", rx_valid); end
        send_bits(8'hC3, 8, got);
        total++; if (got !== 8'h00) begin bad++; $display("FAIL b2b_miso_second got=%h exp=00", got); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_second got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL b2b_data_second got=%h exp=c3", rx_data); end
        ack();
        cs_high();
    endtask

    task automatic test_abort();
        logic [7:0] got;
        cs_low();
        send_bits(8'hF0, 5, got);
        CS = 1'b1;
        #100;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL abort_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL abort_rx_data_kept got=%h exp=c3", rx_data); end
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL abort_miso got=%b exp=0", MISO); end
        cs_low();
        send_bits(8'h81, 8, got);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL abort_next_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL abort_next_data got=%h exp=81", rx_data); end
        ack();
        cs_high();
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        logic [7:0] exp_data;
        cs_low();
        send_bits(8'h11, 8, got);
        send_bits(8'h22, 8, got);
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_data = 8'h11;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
`else
        exp_data = 8'h22;
`endif
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL overrun_rx_data got=%h exp=%h", rx_data, exp_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_rx_valid got=%b exp=1", rx_valid); end
        cs_high();
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] got;
        cs_low();
        load_tx(8'h99);
        send_bits(8'hFF, 4, got);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b exp=0", MISO); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midrst_tx_ready got=%b exp=1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
`ifdef SPI_SLAVE_OVERRUN_EN
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
`endif
        reset = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        #100;
        load_tx(8'h3E);
        cs_low();
        send_bits(8'h5A, 8, got);
        total++; if (got !== 8'h3E) begin bad++; $display("FAIL midrst_miso_byte got=%h exp=3e", got); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL midrst_next_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL midrst_next_data got=%h exp=5a", rx_data); end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
